// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: geometry functions, direction counter
// constants and bit offsets of a packed BTB entry {valid, tag, is_jump, target, ctr}.
package bp_pkg;

  localparam int CTR_W_MAX = 8;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  // Weakly taken: MSB set, rest clear. Weakly not-taken is one below it.
  function automatic logic [CTR_W_MAX-1:0] ctr_wt(input int w);
    return CTR_W_MAX'(1) << (w - 1);
  endfunction

  function automatic logic [CTR_W_MAX-1:0] ctr_wnt(input int w);
    return ctr_wt(w) - CTR_W_MAX'(1);
  endfunction

  function automatic int ent_tgt_lsb(input int ctr_w);
    return ctr_w;
  endfunction

  function automatic int ent_jmp_pos(input int xlen, input int ctr_w);
    return ctr_w + xlen;
  endfunction

  function automatic int ent_tag_lsb(input int xlen, input int ctr_w);
    return ctr_w + xlen + 1;
  endfunction

  function automatic int ent_vld_pos(input int xlen, input int entries, input int ctr_w);
    return ent_tag_lsb(xlen, ctr_w) + tag_w(xlen, entries);
  endfunction

  function automatic int ent_w(input int xlen, input int entries, input int ctr_w);
    return ent_vld_pos(xlen, entries, ctr_w) + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with synchronous load; load wins over inc/dec.
module sat_counter #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters: combinational lookup for IF,
// resolve/update and mispredict redirect from MEM, plus saturating statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  lk_pc,
  output logic             lk_hit,
  output logic             lk_taken,
  output logic [XLEN-1:0]  lk_target,
  input  logic             rs_valid,
  input  logic [XLEN-1:0]  rs_pc,
  input  logic             rs_is_jump,
  input  logic             rs_taken,
  input  logic [XLEN-1:0]  rs_target,
  input  logic             rs_pred_taken,
  input  logic [XLEN-1:0]  rs_pred_target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispred
);

  localparam int IDX_W   = idx_w(ENTRIES);
  localparam int TAG_W   = tag_w(XLEN, ENTRIES);
  localparam int TGT_LSB = ent_tgt_lsb(CTR_W);
  localparam int JMP_POS = ent_jmp_pos(XLEN, CTR_W);
  localparam int TAG_LSB = ent_tag_lsb(XLEN, CTR_W);
  localparam int VLD_POS = ent_vld_pos(XLEN, ENTRIES, CTR_W);
  localparam int ENT_W   = ent_w(XLEN, ENTRIES, CTR_W);
  localparam logic [CTR_W-1:0] WT  = CTR_W'(ctr_wt(CTR_W));
  localparam logic [CTR_W-1:0] WNT = CTR_W'(ctr_wnt(CTR_W));

  logic [ENTRIES-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ENTRIES-1:0] jmp_q;
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [CTR_W-1:0]   ctr   [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [ENT_W-1:0] lk_ent;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[XLEN-1:IDX_W+2];
  assign lk_ent = {vld_q[lk_idx], tag_q[lk_idx], jmp_q[lk_idx], tgt_q[lk_idx], ctr[lk_idx]};

  assign lk_hit    = lk_ent[VLD_POS] && (lk_ent[TAG_LSB +: TAG_W] == lk_tag);
  assign lk_taken  = lk_hit && (lk_ent[JMP_POS] || lk_ent[CTR_W-1]);
  assign lk_target = lk_hit ? lk_ent[TGT_LSB +: XLEN] : '0;

  logic [IDX_W-1:0] rs_idx;
  logic [TAG_W-1:0] rs_tag;
  logic             rs_hit;
  logic             alloc;

  assign rs_idx = rs_pc[IDX_W+1:2];
  assign rs_tag = rs_pc[XLEN-1:IDX_W+2];
  assign rs_hit = vld_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
  assign alloc  = rs_valid && !rs_hit && rs_taken;

  assign mispredict  = rs_valid && ((rs_pred_taken != rs_taken) ||
                                    (rs_taken && (rs_pred_target != rs_target)));
  assign redirect_pc = rs_taken ? rs_target : rs_pc + XLEN'(4);

  // A taken resolve always writes target/kind; a miss additionally claims the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      jmp_q <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        tag_q[e] <= '0;
        tgt_q[e] <= '0;
      end
    end else if (rs_valid && rs_taken) begin
      tgt_q[rs_idx] <= rs_target;
      jmp_q[rs_idx] <= rs_is_jump;
      if (!rs_hit) begin
        vld_q[rs_idx] <= 1'b1;
        tag_q[rs_idx] <= rs_tag;
      end
    end
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
    logic sel;
    assign sel = rs_valid && (rs_idx == IDX_W'(e));

    sat_counter #(
      .W       (CTR_W),
      .RST_VAL (WNT)
    ) u_ctr (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .load_i     (sel && alloc),
      .load_val_i (WT),
      .inc_i      (sel && rs_hit && rs_taken),
      .dec_i      (sel && rs_hit && !rs_taken),
      .cnt_o      (ctr[e])
    );
  end

  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] mp_q, mp_d;

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (stat_clr) begin
      br_d = '0;
      mp_d = '0;
    end else begin
      if (rs_valid && (br_q != {CNT_W{1'b1}})) br_d = br_q + CNT_W'(1);
      if (mispredict && (mp_q != {CNT_W{1'b1}})) mp_d = mp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign stat_branches = br_q;
  assign stat_mispred  = mp_q;

  // Fetch PC alignment bits and the low counter bits of the read view carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{lk_pc[1:0], lk_ent};

endmodule
